// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and registers imem_rd into IF/ID, one-cycle fetch latency.
// stall_d holds IF/ID and PC, stall_f holds PC only; HALTED/FAULT are sticky until reset_n.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 401,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    state_t      state, state_nxt;
    logic [31:0] pc_f, pc_nxt, pc_plus4_f;
    logic        fetch_ok, redir, load, bubble;

    assign imem_a     = pc_f;
    assign pc_plus4_f = pc_f + 32'd4;
    assign halted     = (state == HALTED);
    assign fault      = (state == FAULT);
    assign fetch_ok   = (state == RUN) && (pc_f[1:0] == 2'b00) &&
                        ({2'b00, pc_f[31:2]} < IMEM_LIMIT);
    // Redirects only mean something while running; a stopped core ignores them.
    assign redir      = redirect_valid && (state == RUN);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_f;
        load      = 1'b0;
        bubble    = 1'b0;

        if (state == RUN) begin
            if (redir) begin
                pc_nxt = redirect_pc;
            end else if (!fetch_ok && !stall_d) begin
                // PC stays on the offending address for post-mortem inspection.
                state_nxt = FAULT;
            end else begin
                if (!(stall_f || stall_d))
                    pc_nxt = pc_plus4_f;
                if (!stall_d && !flush_d && fetch_ok && (imem_rd == HALT_INSTR))
                    state_nxt = HALTED;
            end
        end

        if (flush_d || redir)
            bubble = 1'b1;
        else if (stall_d)
            bubble = 1'b0;
        else if (fetch_ok)
            load = 1'b1;
        else
            bubble = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            pc_f  <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc_f  <= pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_d     <= NOP_INSTR;
            pc_d        <= 32'd0;
            pc_plus4_d  <= 32'd0;
            valid_d     <= 1'b0;
            fetch_count <= 32'd0;
        end else if (load) begin
            instr_d     <= imem_rd;
            pc_d        <= pc_f;
            pc_plus4_d  <= pc_plus4_f;
            valid_d     <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end else if (bubble) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural 401-word instruction ROM.
module tb_fetch_stage;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_a, imem_rd, instr_d, pc_d, pc_plus4_d, fetch_count;
    logic        valid_d, halted, fault;

    logic [31:0] rom [0:511];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        if ({2'b00, imem_a[31:2]} < 32'd401)
            imem_rd = rom[imem_a[10:2]];
        else
            imem_rd = 32'hDEAD_BEEF;
    end

    fetch_stage dut (
        .clk(clk), .reset_n(reset_n), .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_a(imem_a), .imem_rd(imem_rd), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pcd,
                            input logic vld, input logic [31:0] cnt);
        chk({tag, ".instr_d"}, instr_d, ins);
        chk({tag, ".pc_d"}, pc_d, pcd);
        chk({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, vld});
        chk({tag, ".fetch_count"}, fetch_count, cnt);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".imem_a"}, imem_a, 32'd0);
        chk_ifid(tag, NOP, 32'd0, 1'b0, 32'd0);
        chk({tag, ".pc_plus4_d"}, pc_plus4_d, 32'd0);
        chk({tag, ".halted"}, {31'd0, halted}, 32'd0);
        chk({tag, ".fault"}, {31'd0, fault}, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge: reset asserts mid-cycle and releases before the next edge.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #2;
        chk_reset(tag);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = BASE + 32'(i);
        rom[5] = HALT;

        #12;
        chk_reset("rst0");
        reset_n = 1'b1;

        // Straight-line fetch of words 0..3.
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_ifid($sformatf("run%0d", k), BASE + 32'(k - 1), 32'(4 * (k - 1)), 1'b1, 32'(k));
            chk($sformatf("run%0d.pc_plus4_d", k), pc_plus4_d, 32'(4 * k));
        end

        pulse_reset("rst1");
        tick();
        tick();
        chk_ifid("preStall", BASE + 32'd1, 32'h4, 1'b1, 32'd2);

        // stall_d freezes IF/ID and PC for every stalled cycle.
        stall_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_ifid($sformatf("stall%0d", k), BASE + 32'd1, 32'h4, 1'b1, 32'd2);
            chk($sformatf("stall%0d.pc_f", k), imem_a, 32'h8);
        end
        stall_d = 1'b0;
        tick();
        chk_ifid("release", BASE + 32'd2, 32'h8, 1'b1, 32'd3);
        tick();
        chk_ifid("preRedir", BASE + 32'd3, 32'hC, 1'b1, 32'd4);
        chk("preRedir.pc_f", imem_a, 32'h10);

        // Redirect: one bubble, then the target word.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk_ifid("redirBubble", NOP, 32'hC, 1'b0, 32'd4);
        chk("redirBubble.pc_f", imem_a, 32'h40);
        tick();
        chk_ifid("redirTarget", BASE + 32'd16, 32'h40, 1'b1, 32'd5);
        chk("redirTarget.pc_plus4_d", pc_plus4_d, 32'h44);

        // Flush beats stall; PC still held by the stall.
        flush_d = 1'b1;
        stall_d = 1'b1;
        tick();
        flush_d = 1'b0;
        stall_d = 1'b0;
        chk_ifid("flushStall", NOP, 32'h40, 1'b0, 32'd5);
        chk("flushStall.pc_f", imem_a, 32'h44);
        tick();
        chk_ifid("afterFlush", BASE + 32'd17, 32'h44, 1'b1, 32'd6);

        // Halt word at 0x14.
        pulse_reset("rst2");
        for (int k = 0; k < 5; k++) tick();
        tick();
        chk_ifid("haltLoad", HALT, 32'h14, 1'b1, 32'd6);
        chk("haltLoad.halted", {31'd0, halted}, 32'd1);
        chk("haltLoad.pc_f", imem_a, 32'h18);
        tick();
        chk_ifid("halted1", NOP, 32'h14, 1'b0, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("haltRedir.pc_f", imem_a, 32'h18);
        chk("haltRedir.halted", {31'd0, halted}, 32'd1);
        chk("haltRedir.fetch_count", fetch_count, 32'd6);

        // Reset while halted, then fetch restarts at RESET_PC.
        pulse_reset("rst3");
        tick();
        chk_ifid("restart", BASE, 32'h0, 1'b1, 32'd1);

        // Sequential run off the end of memory.
        rom[5] = BASE + 32'd5;
        pulse_reset("rst4");
        for (int k = 0; k < 400; k++) tick();
        tick();
        chk_ifid("lastWord", BASE + 32'd400, 32'h640, 1'b1, 32'd401);
        chk("lastWord.pc_f", imem_a, 32'h644);
        chk("lastWord.fault", {31'd0, fault}, 32'd0);
        tick();
        chk_ifid("oobFault", NOP, 32'h640, 1'b0, 32'd401);
        chk("oobFault.fault", {31'd0, fault}, 32'd1);

        // Redirect to a misaligned target faults one edge later.
        pulse_reset("rst5");
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2;
        tick();
        redirect_valid = 1'b0;
        chk("misRedir.pc_f", imem_a, 32'h2);
        chk("misRedir.fault", {31'd0, fault}, 32'd0);
        chk_ifid("misRedir", NOP, 32'h0, 1'b0, 32'd1);
        tick();
        chk("misFault.fault", {31'd0, fault}, 32'd1);
        chk_ifid("misFault", NOP, 32'h0, 1'b0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the CPU pipeline: owns the program counter, drives the word-aligned address into the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register for decode. Handles stall, flush and branch redirect. Detects a halt instruction and out-of-range or misaligned fetches, freezing the PC in a sticky HALTED or FAULT state until reset.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- IMEM_WORDS, 401, instruction memory depth in 32-bit words; valid fetch iff pc_f[31:2] < IMEM_WORDS
- HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch
- NOP_INSTR, 32'h0000_0000, bubble encoding placed in instr_d when valid_d=0

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall_f  in  1  hold PC
- stall_d  in  1  hold IF/ID register (also holds PC)
- flush_d  in  1  squash IF/ID register to bubble
- redirect_valid  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  redirect target
- imem_a  out  32  byte address to instruction memory (= pc_f)
- imem_rd  in  32  instruction returned combinationally for imem_a
- instr_d  out  32  registered instruction for decode
- pc_d  out  32  PC of instr_d
- pc_plus4_d  out  32  pc_d + 4, mod 2^32
- valid_d  out  1  instr_d is a real fetched instruction
- halted  out  1  sticky, HALT_INSTR reached decode
- fault  out  1  sticky, illegal fetch address
- fetch_count  out  32  number of valid instructions loaded into IF/ID, wraps 2^32-1 -> 0

## Operation
- FSM states: RUN, HALTED, FAULT. Reset -> RUN. HALTED and FAULT exit only via reset_n. halted = (state==HALTED), fault = (state==FAULT).
- Fetch legality: fetch_ok = RUN and pc_f[1:0]==0 and pc_f[31:2] < IMEM_WORDS.
- RUN -> FAULT at an edge where fetch_ok=0 (misaligned or out of range) and neither stall_d nor redirect_valid is asserted; faulting address is never loaded as valid.
- RUN -> HALTED at an edge where IF/ID loads (no stall_d, no flush_d, no redirect_valid) with imem_rd==HALT_INSTR and fetch_ok; the halt word is loaded with valid_d=1.
- Next PC priority (RUN only): redirect_valid -> redirect_pc; else stall_f or stall_d -> hold; else pc_f+4 (mod 2^32). In HALTED/FAULT, PC holds; redirect_valid ignored.
- IF/ID priority: flush_d or redirect_valid -> valid_d=0, instr_d=NOP_INSTR, pc_d/pc_plus4_d hold; else stall_d -> all hold; else if fetch_ok -> load imem_rd, pc_f, pc_f+4, valid_d=1; else bubble as above.
- Redirect wins over halt detection and fault in the same cycle (wrong-path fetch is discarded).
- fetch_count increments by 1 on every edge that loads valid_d=1.

## Timing
- Reset (asynchronous, immediate): pc_f=RESET_PC, imem_a=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, halted=0, fault=0, fetch_count=0, state RUN.
- First valid instruction at decode: first rising edge after reset_n deasserts (1-cycle fetch latency).
- imem_a is combinational from pc_f; imem_rd is sampled at the same edge that updates pc_f.
- Redirect: asserted in cycle N -> pc_f=redirect_pc after edge N, instruction at target in instr_d after edge N+1; one bubble in between.
- Redirect to misaligned or out-of-range target: accepted into pc_f, FAULT entered at the following edge.
- Stall: while stall_d=1, instr_d/pc_d/valid_d/pc_f are stable for every stalled cycle; release resumes without loss or duplication.
- Simultaneous flush_d and stall_d: flush wins.
- Reset mid-stall/mid-redirect: reset dominates; no pending redirect survives.

## Test plan
- Reset then run 4 cycles with ROM[0..3]=A,B,C,D: instr_d=A,B,C,D on edges 1-4, pc_d=0,4,8,12, fetch_count=4.
- stall_d high 3 cycles while instr_d=B (pc_d=4): outputs frozen; after release, C at pc_d=8 next edge, fetch_count counts B once.
- redirect_valid with redirect_pc=0x40 while pc_f=0x10: one bubble (valid_d=0, instr_d=NOP_INSTR), then instr_d=ROM[16], pc_d=0x40.
- ROM[5]=HALT_INSTR: halt word reaches decode with valid_d=1, halted=1 next, pc_f frozen at 0x18, later valid_d=0; redirect ignored.
- Sequential run past word 400 (pc_f=0x644): fault=1, no valid load for 0x644; redirect_pc=0x2 likewise faults one edge after redirect.
- Assert reset_n=0 mid-cycle while halted: all outputs return immediately to reset values; fetching restarts from RESET_PC.
